// File: rtl/bus_ctrl_pkg.sv
// Shared bus controller types: word and long-word data types, the L2
// responder status encoding, and small address helpers used by the
// responder to map byte addresses onto 64-bit backing entries.
package bus_ctrl_pkg;

  // Number of CPUs served by the bus controller.
  localparam int unsigned CPUS = 2;

  // Bytes per backing entry, expressed as a shift amount.
  localparam int unsigned LONG_WORD_SHIFT = 3;

  typedef logic [31:0] word_t;
  typedef logic [63:0] longWord_t;

  // Responder status as seen by the bus controller.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } l2_state_t;

  // Long-word entry number of a byte address relative to the window base.
  // The low three byte-offset bits fall away in the shift.
  function automatic word_t entryOf(word_t addr, word_t base);
    return (addr - base) >> LONG_WORD_SHIFT;
  endfunction

  // True when the byte address falls inside base .. base + 8*depth - 1.
  // Addresses below base wrap to large offsets and therefore fail.
  function automatic logic inWindow(word_t addr, word_t base, int unsigned depth);
    logic [63:0] offset;
    logic [63:0] span;
    offset = 64'(addr - base);
    span   = 64'(depth) << LONG_WORD_SHIFT;
    return offset < span;
  endfunction

  // True when the byte address is aligned to a 64-bit entry.
  function automatic logic isAligned(word_t addr);
    return addr[2:0] == 3'b000;
  endfunction

endpackage

// File: rtl/l2_mem_responder_if.sv
// Request/response bundle between the bus controller (master) and the
// L2 memory responder (slave).
interface l2_mem_responder_if;
  import bus_ctrl_pkg::*;

  logic      l2REN;
  logic      l2WEN;
  word_t     l2addr;
  longWord_t l2store;
  longWord_t l2load;
  l2_state_t l2state;

  modport master (
    output l2REN,
    output l2WEN,
    output l2addr,
    output l2store,
    input  l2load,
    input  l2state
  );

  modport slave (
    input  l2REN,
    input  l2WEN,
    input  l2addr,
    input  l2store,
    output l2load,
    output l2state
  );

endinterface

// File: rtl/l2_backing_ram.sv
// Synchronous single-port 64-bit backing store for the L2 responder.
// One read or one write per enabled cycle. Read data is registered and
// holds its value until the next enabled read; writes leave it alone.
// The storage array itself is never cleared; only the read register is.
module l2_backing_ram
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  longWord_t        wdata_i,
  output longWord_t        rdata_o
);

  longWord_t mem [DEPTH];
  longWord_t rdata_q;

  // Commit a write into the array when enabled for a write.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem[idx_i] <= wdata_i;
    end
  end

  // Capture read data on an enabled read; clear only the output register.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/l2_mem_responder.sv
// L2 memory responder: accepts one read or write at a time from the bus
// controller, waits LATENCY cycles, then performs the access against the
// backing RAM and reports ACCESS for one cycle.
//
// Build option: define L2_RESPONDER_ERRCHK_EN to reject simultaneous
// read+write, misaligned addresses and addresses outside the window with a
// one-cycle ERROR. Without it, ERROR never occurs, a write wins over a read,
// the low three address bits are ignored and the entry index wraps.
module l2_mem_responder
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned DEPTH     = 256,
  parameter word_t       BASE_ADDR = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              nRST,
  l2_mem_responder_if.slave l2Bus
);

  localparam int unsigned IDX_W            = $clog2(DEPTH);
  localparam logic        ACCEPT_TO_ACCESS = (LATENCY == 1);
  localparam logic [3:0]  COUNT_LOAD       = 4'(LATENCY - 1);

  l2_state_t  state_q;
  logic [3:0] count_q;
  word_t      addr_q;
  longWord_t  data_q;
  logic       isWrite_q;

  logic             reqValid;
  logic             reqWrite;
  logic             reqErr;
  logic [IDX_W-1:0] reqIdx;
  logic [IDX_W-1:0] latIdx;

  logic             ramEn;
  logic             ramWe;
  logic [IDX_W-1:0] ramIdx;
  longWord_t        ramWData;
  longWord_t        ramRData;

  assign reqValid = l2Bus.l2REN | l2Bus.l2WEN;
  assign reqWrite = l2Bus.l2WEN;
  assign reqIdx   = IDX_W'(entryOf(l2Bus.l2addr, BASE_ADDR));
  assign latIdx   = IDX_W'(entryOf(addr_q, BASE_ADDR));

`ifdef L2_RESPONDER_ERRCHK_EN
  assign reqErr = (l2Bus.l2REN & l2Bus.l2WEN)
                | !isAligned(l2Bus.l2addr)
                | !inWindow(l2Bus.l2addr, BASE_ADDR, DEPTH);
`else
  assign reqErr = 1'b0;
`endif

  // Drive the RAM only on the edge that enters ACCESS; with single-cycle
  // latency that edge is also the accepting edge, so use the live request.
  always_comb begin
    ramEn    = 1'b0;
    ramWe    = 1'b0;
    ramIdx   = latIdx;
    ramWData = data_q;
    if (ACCEPT_TO_ACCESS && state_q == FREE && reqValid && !reqErr) begin
      ramEn    = nRST;
      ramWe    = reqWrite;
      ramIdx   = reqIdx;
      ramWData = l2Bus.l2store;
    end else if (state_q == BUSY && count_q == 4'd1) begin
      ramEn    = nRST;
      ramWe    = isWrite_q;
    end
  end

  // Responder state machine: accept in FREE, count down in BUSY, and hold
  // ACCESS or ERROR for exactly one cycle before returning to FREE.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= FREE;
      count_q   <= 4'd0;
      addr_q    <= '0;
      data_q    <= '0;
      isWrite_q <= 1'b0;
    end else begin
      case (state_q)
        FREE: begin
          if (reqValid) begin
            addr_q    <= l2Bus.l2addr;
            data_q    <= l2Bus.l2store;
            isWrite_q <= reqWrite;
            if (reqErr) begin
              state_q <= ERROR;
              count_q <= 4'd0;
            end else if (ACCEPT_TO_ACCESS) begin
              state_q <= ACCESS;
              count_q <= 4'd0;
            end else begin
              state_q <= BUSY;
              count_q <= COUNT_LOAD;
            end
          end
        end
        BUSY: begin
          if (count_q == 4'd1) begin
            state_q <= ACCESS;
            count_q <= 4'd0;
          end else begin
            count_q <= count_q - 4'd1;
          end
        end
        ACCESS: state_q <= FREE;
        ERROR:  state_q <= FREE;
        default: state_q <= FREE;
      endcase
    end
  end

  l2_backing_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk_i   (CLK),
    .clr_i   (!nRST),
    .en_i    (ramEn),
    .we_i    (ramWe),
    .idx_i   (ramIdx),
    .wdata_i (ramWData),
    .rdata_o (ramRData)
  );

  assign l2Bus.l2load  = ramRData;
  assign l2Bus.l2state = state_q;

endmodule

// File: doc/l2_mem_responder.md
L2_MEM_RESPONDER -- requirements
Module: l2_mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, giving cycles from request acceptance to ACCESS; legal range 1..15.
REQ-002 The block SHALL have parameter DEPTH, default 256, giving the number of 64-bit backing entries; power of two.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of entry 0.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port nRST, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port l2REN, input, 1 bit: read request from the bus controller.
REQ-007 The block SHALL have port l2WEN, input, 1 bit: write request from the bus controller.
REQ-008 The block SHALL have port l2addr, input, word_t (32 bits): byte address of the request.
REQ-009 The block SHALL have port l2store, input, longWord_t (64 bits): write data.
REQ-010 The block SHALL have port l2load, output, longWord_t (64 bits): read data.
REQ-011 The block SHALL have port l2state, output, l2_state_t (2 bits): responder status, one of FREE, BUSY, ACCESS or ERROR.

Function
REQ-012 The l2state register SHALL be the state machine.
- FREE: idle.
- BUSY: counting.
- ACCESS: one cycle, transaction complete.
- ERROR: one cycle, transaction rejected.
REQ-013 In FREE with l2REN or l2WEN high at an edge, the block SHALL latch addr, data and op (accept), and load the counter with LATENCY-1.
REQ-014 After acceptance, the next state SHALL be BUSY if LATENCY>1, else ACCESS.
REQ-015 In BUSY, the counter SHALL decrement each cycle; the transition to ACCESS SHALL occur on the edge where the counter equals 1; ACCESS is therefore first visible exactly LATENCY cycles after the accepting edge.
REQ-016 Write commit SHALL occur on the edge entering ACCESS (entry = (latched addr - BASE_ADDR)>>3); read data SHALL be registered into l2load on that same edge.
REQ-017 l2load SHALL hold its value until the next read completes; writes SHALL NOT change l2load.
REQ-018 ACCESS and ERROR SHALL each last exactly one cycle, then return to FREE; a request is never accepted in ACCESS, ERROR or BUSY.
REQ-019 Back-to-back: a request held high through ACCESS SHALL be accepted at the first FREE edge, i.e. a minimum of one FREE cycle between transactions.
REQ-020 Request inputs changing during BUSY SHALL be ignored; latched values SHALL be used.
REQ-021 A read after a write to the same entry SHALL return the written data.

Reset
REQ-022 With nRST low at an edge, l2state SHALL become FREE, the counter 0, l2load 64'h0 and latched request 0.
REQ-023 Reset in BUSY SHALL abort the transaction with no write committed.
REQ-024 Backing array contents SHALL NOT be reset.

Configuration
REQ-025 Macro L2_RESPONDER_ERRCHK_EN SHALL control error checking.
- Defined: at acceptance, the next state SHALL be ERROR (no counting, no write, l2load unchanged) when any of the following hold: l2REN and l2WEN are both high, l2addr[2:0]!=0, or the address lies outside BASE_ADDR..BASE_ADDR+8*DEPTH-1.
- Undefined: ERROR SHALL never be produced; l2WEN SHALL take priority over l2REN; the index SHALL be the low log2(DEPTH) bits of (addr-BASE_ADDR)>>3 (wrap-around); l2addr[2:0] SHALL be ignored.

Structure
REQ-026 l2_state_t, word_t, longWord_t and CPUS SHALL live in shared package bus_ctrl_pkg, imported by this block and by the bus controller interface.
REQ-027 The backing array SHALL be sub-module l2_backing_ram (synchronous single-port: one read or one write per cycle, 64-bit, DEPTH entries).

Verification
REQ-028 The bench SHALL cover the following directed scenarios (LATENCY=4, BASE_ADDR=0):
- Write then read: WEN, addr 0x10, data 64'hDEAD_BEEF_0123_4567 -> BUSY 3 cycles, ACCESS at cycle 4; then REN at 0x10 -> ACCESS with l2load=64'hDEAD_BEEF_0123_4567.
- LATENCY=1: REN at 0x0 -> ACCESS on the very next cycle, no BUSY.
- Reset mid-transaction: nRST low during the second BUSY cycle of a write of 64'h1 to 0x20 -> FREE; a subsequent read of 0x20 does not return 64'h1 (preloaded 64'h0).
- ERRCHK_EN defined: REN at 0x804 with DEPTH=256 -> ERROR one cycle then FREE; REN and WEN together -> ERROR.
- ERRCHK_EN undefined: WEN at 0x808 with DEPTH=256 (aliases entry 1) -> ACCESS; read of 0x8 returns that data.
- Request held high across ACCESS -> exactly one FREE cycle, then re-accept; inputs changed during BUSY -> no effect on the result.
